// File: rtl/scan_ctrl.sv
// scan_ctrl: serialises one WIDTH-bit word MSB first into an external pattern
// detector and counts the cycles in which the detector reports a match.
//
// Sequence per scan: IDLE -> CLEAR (det_clr pulse) -> SHIFT (WIDTH bits)
// -> DRAIN (catches the registered hit of the last bit) -> DONE (done pulse).
//
// Build option:
//   SCAN_CTRL_HIT_SAT_EN  defined   : hit_count saturates at 2^CNT_W-1
//   SCAN_CTRL_HIT_SAT_EN  undefined : hit_count wraps modulo 2^CNT_W
//
// Every output is a flop, so there is no combinational path from any input.
module scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din_word,
  input  logic             det_hit,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] hit_inc;
  logic [WIDTH-1:0] shreg_shl;

  // Next value of the hit counter when a hit is taken.
`ifdef SCAN_CTRL_HIT_SAT_EN
  assign hit_inc = (hit_count == {CNT_W{1'b1}}) ? hit_count : hit_count + CNT_W'(1);
`else
  assign hit_inc = hit_count + CNT_W'(1);
`endif

  // Shift register moved one place towards the MSB.
  assign shreg_shl = {shreg[WIDTH-2:0], 1'b0};

  // Scan sequencer: state, datapath and all registered outputs.
  // ser_bit is loaded one edge ahead of the cycle it is shown in, so CLEAR
  // already pulls the first bit out of the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      hit_count <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      det_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort has no meaning here, so start always wins
          if (start) begin
            shreg     <= din_word;
            idx       <= '0;
            hit_count <= '0;
            det_clr   <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          det_clr <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ser_valid <= 1'b1;
            ser_bit   <= shreg[WIDTH-1];
            shreg     <= shreg_shl;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            // hit_count is left untouched: the partial count stays visible
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            if (det_hit) begin
              hit_count <= hit_inc;
            end
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              ser_valid <= 1'b0;
              ser_bit   <= 1'b0;
              state     <= DRAIN;
            end else begin
              ser_bit <= shreg[WIDTH-1];
              shreg   <= shreg_shl;
            end
          end
        end

        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // detector output for the final bit arrives in this cycle
            if (det_hit) begin
              hit_count <= hit_inc;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // start and abort are both ignored here
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          ser_bit   <= 1'b0;
          ser_valid <= 1'b0;
          det_clr   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed bench for scan_ctrl (WIDTH=8).
// Two instances share all inputs: CNT_W=5 for the main counts and CNT_W=2 to
// exercise wrap (default) or saturation (SCAN_CTRL_HIT_SAT_EN defined).
// Expected serial bits and final hit counts are queued when a scan is
// launched and consumed by a monitor when the DUT presents them.
module tb_scan_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         det_hit;
  logic [W-1:0] din_word;

  logic         ser_bit, ser_valid, det_clr, busy, done;
  logic [4:0]   hit_count;
  logic         s_ser_bit, s_ser_valid, s_det_clr, s_busy, s_done;
  logic [1:0]   s_hit_count;

  int n_total = 0;
  int n_pass  = 0;

  bit sb_bits[$];
  int sb_hit[$];
  int sb_hit_s[$];

  scan_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .din_word(din_word), .det_hit(det_hit),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .det_clr(det_clr),
    .busy(busy), .done(done), .hit_count(hit_count)
  );

  scan_ctrl #(.WIDTH(W), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .din_word(din_word), .det_hit(det_hit),
    .ser_bit(s_ser_bit), .ser_valid(s_ser_valid), .det_clr(s_det_clr),
    .busy(s_busy), .done(s_done), .hit_count(s_hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: consume expected serial bits and completion counts.
  always @(negedge clk) begin
    bit b;
    int e, es;
    if (ser_valid === 1'b1) begin
      chk("ser_bit_expected", (sb_bits.size() != 0), 1);
      if (sb_bits.size() != 0) begin
        b = sb_bits.pop_front();
        chk("ser_bit", ser_bit, b);
        chk("s_ser_bit", s_ser_bit, b);
      end
    end else begin
      chk("ser_bit_idle_zero", ser_bit, 0);
      chk("s_ser_bit_idle_zero", s_ser_bit, 0);
    end
    if (done === 1'b1) begin
      chk("done_expected", (sb_hit.size() != 0), 1);
      if (sb_hit.size() != 0) begin
        e  = sb_hit.pop_front();
        es = sb_hit_s.pop_front();
        chk("hit_count_at_done", hit_count, e);
        chk("s_hit_count_at_done", s_hit_count, es);
        $display("scan complete: hit_count=%0d (exp %0d) small=%0d (exp %0d)",
                 hit_count, e, s_hit_count, es);
      end
    end
  end

  task automatic chk_outputs(input string tag, input logic e_clr, input logic e_valid,
                             input logic e_busy, input logic e_done);
    chk({tag, " det_clr"}, det_clr, e_clr);
    chk({tag, " ser_valid"}, ser_valid, e_valid);
    chk({tag, " busy"}, busy, e_busy);
    chk({tag, " done"}, done, e_done);
    chk({tag, " s_det_clr"}, s_det_clr, e_clr);
    chk({tag, " s_ser_valid"}, s_ser_valid, e_valid);
    chk({tag, " s_busy"}, s_busy, e_busy);
    chk({tag, " s_done"}, s_done, e_done);
  endtask

  // One scan launched from an IDLE negedge (cycle 0). mask[c] drives det_hit
  // during cycle c. abort_at>0 raises abort in that cycle. hold keeps start
  // high through the scan. abort0 raises abort together with start.
  task automatic scan(input logic [7:0] w, input logic [15:0] mask, input int abort_at,
                      input bit hold, input bit abort0, input string name);
    int  m = 0;
    int  s = 0;
    bit  live;
    for (int c = 2; c <= 10; c++) begin
      if (mask[c] && (abort_at == 0 || c < abort_at)) begin
        m++;
`ifdef SCAN_CTRL_HIT_SAT_EN
        s = (s == 3) ? 3 : s + 1;
`else
        s = (s + 1) % 4;
`endif
      end
    end
    for (int c = 2; c <= 9; c++) begin
      if (abort_at == 0 || c <= abort_at) sb_bits.push_back(w[9-c]);
    end
    if (abort_at == 0) begin
      sb_hit.push_back(m);
      sb_hit_s.push_back(s);
    end
    start    = 1'b1;
    din_word = w;
    abort    = abort0;
    det_hit  = mask[0];
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      live = (abort_at == 0) || (c <= abort_at);
      chk_outputs($sformatf("%s c%0d", name, c), live && c == 1,
                  live && c >= 2 && c <= 9, live && c <= 11, live && c == 11);
      if (abort_at == 0 && c == 12) begin
        chk($sformatf("%s hit_hold", name), hit_count, m);
        chk($sformatf("%s s_hit_hold", name), s_hit_count, s);
      end
      if (abort_at != 0 && c > abort_at) begin
        chk($sformatf("%s hit_frozen c%0d", name, c), hit_count, m);
        chk($sformatf("%s s_hit_frozen c%0d", name, c), s_hit_count, s);
      end
      start   = (c < 12) ? hold : 1'b0;
      abort   = (c == abort_at);
      det_hit = mask[c];
    end
    $display("scan %s word=%02h mask=%04h abort_at=%0d expected hits=%0d", name, w, mask,
             abort_at, m);
  endtask

  task automatic chk_reset_values(input string tag);
    chk_outputs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, " ser_bit"}, ser_bit, 0);
    chk({tag, " hit_count"}, hit_count, 0);
    chk({tag, " s_hit_count"}, s_hit_count, 0);
  endtask

  initial begin
    logic [7:0] rw;
    rst_n    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    det_hit  = 1'b0;
    din_word = '0;
    #1 rst_n = 1'b0;

    // reset values, during reset and in the first cycle after release
    @(negedge clk);
    chk_reset_values("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_values("after_release");

    // basic scan: hits in CLEAR (ignored), cycles 4, 5 and DRAIN
    scan(8'hB4, 16'h0432, 0, 1'b0, 1'b0, "b4");
    // five hits in SHIFT: small counter wraps or saturates
    scan(8'h3C, 16'h007C, 0, 1'b0, 1'b0, "five_hits");
    // start held high: back-to-back scans, hits in DONE/IDLE ignored
    scan(8'h5A, 16'h1A00, 0, 1'b1, 1'b0, "hold0");
    scan(8'hFF, 16'h03FE, 0, 1'b1, 1'b0, "hold1");
    scan(8'h01, 16'h0401, 0, 1'b0, 1'b0, "hold2");
    // abort in cycle 5 after two hits
    scan(8'hA5, 16'h0018, 5, 1'b0, 1'b0, "abort");
    // start and abort together in IDLE: start wins
    scan(8'h69, 16'h0380, 0, 1'b0, 1'b1, "after_abort");

    // asynchronous reset mid-scan (cycle 6, between edges)
    rw       = 8'hC3;
    start    = 1'b1;
    din_word = rw;
    for (int c = 2; c <= 5; c++) sb_bits.push_back(rw[9-c]);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst_scan busy c%0d", c), busy, 1);
      start   = 1'b0;
      det_hit = (c == 3);
    end
    det_hit = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    @(negedge clk);
    chk_reset_values("held_reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_values("reset_release2");

    // first start after reset runs a full scan
    scan(8'h96, 16'h0004, 0, 1'b0, 1'b0, "after_reset");

    chk("bits_left", sb_bits.size(), 0);
    chk("scans_left", sb_hit.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of bits in one scan word (range 2..64).
REQ-002 SHALL have parameter CNT_W, default 5, width of the hit counter (range 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to scan din_word; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a scan in progress.
REQ-007 SHALL have port din_word  input  WIDTH  word to serialise; captured on the accepted start.
REQ-008 SHALL have port det_hit  input  1  detector match output; registered, one cycle behind ser_bit.
REQ-009 SHALL have port ser_bit  output  1  serial bit presented to the detector's d_in.
REQ-010 SHALL have port ser_valid  output  1  high in each cycle in which ser_bit carries a scan bit.
REQ-011 SHALL have port det_clr  output  1  one-cycle clear pulse to the detector before each scan.
REQ-012 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking completion; hit_count valid.
REQ-014 SHALL have port hit_count  output  CNT_W  number of det_hit cycles counted in the last scan.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, SHIFT, DRAIN and DONE in a registered state machine.
REQ-016 IDLE with start=1: capture din_word into the shift register, zero hit_count and the bit index, then go to CLEAR. Otherwise stay in IDLE.
REQ-017 CLEAR: det_clr=1 for exactly this one cycle; next state SHIFT.
REQ-018 SHIFT: ser_valid=1 and ser_bit=shreg[WIDTH-1] (MSB first); shift left by one bit and increment the index each cycle; after WIDTH cycles go to DRAIN.
REQ-019 DRAIN: one cycle with ser_valid=0, to catch the registered hit of the last bit; next state DONE.
REQ-020 DONE: done=1 for one cycle; next state IDLE; hit_count holds until the next accepted start.
REQ-021 In SHIFT or DRAIN, det_hit=1 SHALL increment hit_count by 1 at the clock edge; det_hit SHALL be ignored in all other states.
REQ-022 Latency: for start accepted at edge 0, CLEAR occupies cycle 1, SHIFT cycles 2..WIDTH+1, DRAIN cycle WIDTH+2, and done=1 in cycle WIDTH+3.
REQ-023 start SHALL be ignored while busy=1; a start in the DONE cycle SHALL NOT be accepted, and start is accepted from the following IDLE cycle.
REQ-024 abort=1 in CLEAR, SHIFT or DRAIN: next state IDLE, no done pulse, hit_count frozen at its current value. abort SHALL be ignored in IDLE and DONE.
REQ-025 abort and start both high in IDLE: start wins (abort is ignored in IDLE).
REQ-026 ser_bit SHALL be 0 whenever ser_valid=0.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, with shift register, index and hit_count cleared, independent of clk.
REQ-029 During reset and in the first cycle after release: ser_bit=0, ser_valid=0, det_clr=0, busy=0, done=0, hit_count=0.
REQ-030 Reset asserted mid-scan SHALL discard the scan without a done pulse; the first start after release SHALL run a complete scan.

Configuration
REQ-031 Macro SCAN_CTRL_HIT_SAT_EN defined: hit_count SHALL saturate at 2^CNT_W-1.
REQ-032 Macro SCAN_CTRL_HIT_SAT_EN undefined: hit_count SHALL wrap modulo 2^CNT_W.

Verification
REQ-033 WIDTH=8, din_word=8'hB4, start pulse at edge 0 -> ser_bit sequence 1,0,1,1,0,1,0,0 in cycles 2..9; det_clr=1 only in cycle 1; done=1 only in cycle 11.
REQ-034 WIDTH=8, det_hit=1 in cycles 4, 5 and 10 (DRAIN) and in cycle 1 (CLEAR) -> hit_count=3 at done.
REQ-035 CNT_W=2, det_hit=1 for 5 cycles within SHIFT -> hit_count=3 with SCAN_CTRL_HIT_SAT_EN defined, hit_count=1 without it.
REQ-036 start held high continuously -> scans begin at edges 0, 12, 24 (WIDTH=8); exactly one done pulse per scan.
REQ-037 abort=1 in cycle 5 -> busy=0 in cycle 6, no done pulse; a new start then yields a full scan with a correct hit_count.
REQ-038 rst_n driven low between clock edges in cycle 6 -> all outputs at reset values immediately; done never pulses for the interrupted scan.
